multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle RV32I control unit replacing the single-cycle decoder. A state machine sequences each instruction through fetch, decode, execute, memory and writeback, and drives all datapath strobes. Instruction and data memories use ready handshakes with a parametrised wait timeout. It decodes the full RV32I base integer set except FENCE/SYSTEM, and enters a sticky trap state on an illegal opcode or a bus timeout.

## Interface
- MAX_WAIT, 16: maximum wait cycles per memory access before bus error; 0 disables the timeout.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- op  in  7  opcode from the held instruction register (IR).
- func3  in  3  IR[14:12].
- func7  in  7  IR[31:25]; only bit 5 is used.
- alu_zero  in  1  ALU result == 0.
- alu_last_bit  in  1  ALU result bit 0 (SLT/SLTU outcome).
- imem_ready  in  1  instruction memory has accepted or returned data this cycle.
- dmem_ready  in  1  data memory has completed the access this cycle.
- imem_req  out  1  fetch request.
- ir_load  out  1  latch instruction into IR.
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- alu_a_source  out  1  ALU operand A: 0 = rs1, 1 = PC.
- alu_source  out  1  ALU operand B: 0 = rs2, 1 = immediate.
- imm_source  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- mem_read  out  1  data load request.
- mem_write  out  1  data store request.
- reg_write  out  1  register file write enable.
- result_source  out  2  write data: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
- pc_write  out  1  PC update enable.
- pc_source  out  2  next PC: 00 PC+4, 01 PC+imm, 10 ALU result with bit 0 cleared.
- retire  out  1  one-cycle pulse on the last cycle of each instruction.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  01 illegal opcode, 10 bus timeout, 00 otherwise.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are combinational from state, op/func3/func7, ALU flags and the ready inputs. Every strobe not listed for a state is 0.
- **FETCH:** imem_req=1. When imem_ready=1, assert ir_load and go to DECODE; otherwise stay.
- **DECODE:** one cycle with no strobes. An unknown op goes to TRAP with cause 01; otherwise go to EXEC.
- **EXEC, by opcode:**
  - OP (0110011) and OP-IMM (0010011): alu_source = 0 or 1 respectively; alu_control from func3. 000 gives ADD, or SUB only for OP with func7[5]. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (func7[5]), 110 OR, 111 AND. Next state WB.
  - LOAD (0000011) and STORE (0100011): ADD with alu_source=1; imm_source I or S respectively. Next state MEM.
  - BRANCH (1100011): imm_source=B; pc_write=1; retire=1; next state FETCH.
    - 000/001: SUB; taken if alu_zero is 1 or 0 respectively.
    - 100/101: SLT; 110/111: SLTU; taken if alu_last_bit is 1 (100/110) or 0 (101/111).
    - func3 010/011 are illegal and go to TRAP.
    - pc_source = 01 if taken, else 00.
  - JAL (1101111) / JALR (1100111): reg_write=1, result_source=10, pc_write=1, retire=1, next state FETCH.
    - JAL: imm_source=J, pc_source=01.
    - JALR: ADD with alu_source=1, imm_source=I, pc_source=10.
  - LUI (0110111): imm_source=U; next state WB.
  - AUIPC (0010111): ADD with alu_a_source=1, alu_source=1, imm_source=U; next state WB.
- **MEM:** hold EXEC ALU controls and assert mem_read (load) or mem_write (store) until dmem_ready.
  - Load: go to WB.
  - Store: pc_write=1, pc_source=00, retire=1, go to FETCH.
- **WB:** reg_write=1; pc_write=1; pc_source=00; retire=1; go to FETCH.
  - result_source: 01 for loads, 11 for LUI, 00 otherwise.
  - ALU controls are held from EXEC.
- **Wait counter:**
  - Width $clog2(MAX_WAIT+1). It clears on entry to FETCH or MEM and increments each cycle the relevant ready is 0.
  - When the counter equals MAX_WAIT with ready still 0, go to TRAP with cause 10. MAX_WAIT=0 never times out.
- **TRAP:** all strobes 0; trap=1; trap_cause is latched. TRAP is left only by rst.

## Timing
- Reset value: the state is FETCH next cycle, the counter and trap_cause are 0, and all outputs are 0 during the reset cycle. Reset asserted mid-instruction aborts it with no pc_write/reg_write/mem_* in that cycle.
- Latency with zero wait (ready high on first request cycle), counted in cycles:
  - Branch/JAL/JALR: 3.
  - ALU op, LUI, AUIPC, store: 4.
  - Load: 5.
- Each wait cycle adds one cycle. A request stays high until the cycle ready is seen, and ready is ignored in all other states.
- A timeout fires on the cycle when MAX_WAIT waits have already elapsed. The access is then abandoned: no ir_load, no WB.
- Exactly one retire pulse per completed instruction; none for trapped instructions.

## Test plan
- ADD x3,x1,x2 (0x002081B3), zero wait. Required:
  - imem_req/ir_load at cycle 0, EXEC alu_control=0000 alu_source=0.
  - WB reg_write=1 result_source=00 pc_write=1 retire=1 at cycle 3.
  - Same flow for SUB (func7=0100000) gives 0001, and ADDI with func7[5]=1 still gives 0000.
- LW, dmem_ready low for 3 cycles: mem_read high for 4 cycles, WB result_source=01 at cycle 7, retire once.
- BNE (func3=001) twice: alu_zero=0 gives pc_source=01; alu_zero=1 gives 00. Both take 3 cycles with alu_control=0001. BLTU with alu_last_bit=1 is taken, alu_control=0110.
- JALR: EXEC reg_write=1, result_source=10, pc_source=10, pc_write=1, retire=1.
- Opcode 0000000: DECODE to TRAP, trap=1, trap_cause=01, no retire. Holds 100 cycles until rst, then imem_req resumes the cycle after rst deasserts.
- MAX_WAIT=4, imem_ready stuck low: TRAP with cause 10 after 5 FETCH cycles. Repeat with MAX_WAIT=0: no trap after 1000 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle RV32I control unit. Sequences each instruction
//                through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
//                strobes, bounds memory waits and traps on illegal opcodes
//                or bus timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       alu_zero,
  input  logic       alu_last_bit,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_load,
  output logic [3:0] alu_control,
  output logic       alu_a_source,
  output logic       alu_source,
  output logic [2:0] imm_source,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_source,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  // A zero-width counter is illegal, so MAX_WAIT=0 still gets one bit.
  localparam int c_cnt_w = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(MAX_WAIT);

  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_and  = 4'd2;
  localparam logic [3:0] c_alu_or   = 4'd3;
  localparam logic [3:0] c_alu_xor  = 4'd4;
  localparam logic [3:0] c_alu_slt  = 4'd5;
  localparam logic [3:0] c_alu_sltu = 4'd6;
  localparam logic [3:0] c_alu_sll  = 4'd7;
  localparam logic [3:0] c_alu_srl  = 4'd8;
  localparam logic [3:0] c_alu_sra  = 4'd9;

  localparam logic [2:0] c_imm_i = 3'd0;
  localparam logic [2:0] c_imm_s = 3'd1;
  localparam logic [2:0] c_imm_b = 3'd2;
  localparam logic [2:0] c_imm_j = 3'd3;
  localparam logic [2:0] c_imm_u = 3'd4;

  localparam logic [1:0] c_res_alu  = 2'b00;
  localparam logic [1:0] c_res_mem  = 2'b01;
  localparam logic [1:0] c_res_link = 2'b10;
  localparam logic [1:0] c_res_imm  = 2'b11;

  localparam logic [1:0] c_pc_plus4 = 2'b00;
  localparam logic [1:0] c_pc_imm   = 2'b01;
  localparam logic [1:0] c_pc_alu   = 2'b10;

  localparam logic [1:0] c_cause_illegal = 2'b01;
  localparam logic [1:0] c_cause_timeout = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_wait;
  logic [1:0]           r_cause;
  logic [1:0]           w_cause;
  logic [3:0]           w_alu_ctl;
  logic                 w_alu_a_pc;
  logic                 w_alu_b_imm;
  logic [2:0]           w_imm_sel;
  logic                 w_op_legal;
  logic                 w_br_taken;
  logic                 w_br_illegal;
  logic                 w_timeout;
  logic                 w_wait_inc;
  logic                 w_unused;

  // Only func7[5] distinguishes SUB/SRA; the remaining bits are don't-care.
  assign w_unused     = ^{func7[6], func7[4:0]};
  assign w_br_illegal = (func3[2:1] == 2'b01);
  assign w_timeout    = (MAX_WAIT != 0) && (r_wait == c_wait_limit);
  assign w_wait_inc   = ((r_state == S_FETCH) && !imem_ready) ||
                        ((r_state == S_MEM)   && !dmem_ready);

  // Opcode decode: ALU operation and operand/immediate selection, held from EXEC through WB.
  always_comb begin
    w_alu_ctl   = c_alu_add;
    w_alu_a_pc  = 1'b0;
    w_alu_b_imm = 1'b0;
    w_imm_sel   = c_imm_i;
    w_op_legal  = 1'b1;
    case (op)
      c_op_op, c_op_imm: begin
        w_alu_b_imm = (op == c_op_imm);
        case (func3)
          3'b000:  w_alu_ctl = ((op == c_op_op) && func7[5]) ? c_alu_sub : c_alu_add;
          3'b001:  w_alu_ctl = c_alu_sll;
          3'b010:  w_alu_ctl = c_alu_slt;
          3'b011:  w_alu_ctl = c_alu_sltu;
          3'b100:  w_alu_ctl = c_alu_xor;
          3'b101:  w_alu_ctl = func7[5] ? c_alu_sra : c_alu_srl;
          3'b110:  w_alu_ctl = c_alu_or;
          default: w_alu_ctl = c_alu_and;
        endcase
      end
      c_op_load:  w_alu_b_imm = 1'b1;
      c_op_store: begin
        w_alu_b_imm = 1'b1;
        w_imm_sel   = c_imm_s;
      end
      c_op_branch: begin
        w_imm_sel = c_imm_b;
        w_alu_ctl = func3[2] ? (func3[1] ? c_alu_sltu : c_alu_slt) : c_alu_sub;
      end
      c_op_jal:  w_imm_sel = c_imm_j;
      c_op_jalr: w_alu_b_imm = 1'b1;
      c_op_lui:  w_imm_sel = c_imm_u;
      c_op_auipc: begin
        w_alu_a_pc  = 1'b1;
        w_alu_b_imm = 1'b1;
        w_imm_sel   = c_imm_u;
      end
      default: w_op_legal = 1'b0;
    endcase
  end

  // Branch outcome from the ALU flags; odd func3 codes invert the condition.
  always_comb begin
    case (func3)
      3'b000:         w_br_taken = alu_zero;
      3'b001:         w_br_taken = !alu_zero;
      3'b100, 3'b110: w_br_taken = alu_last_bit;
      3'b101, 3'b111: w_br_taken = !alu_last_bit;
      default:        w_br_taken = 1'b0;
    endcase
  end

  // Next-state and strobe generation; every output is forced low while rst is high.
  always_comb begin
    w_next        = r_state;
    w_cause       = 2'b00;
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    alu_control   = c_alu_add;
    alu_a_source  = 1'b0;
    alu_source    = 1'b0;
    imm_source    = c_imm_i;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_source = c_res_alu;
    pc_write      = 1'b0;
    pc_source     = c_pc_plus4;
    retire        = 1'b0;
    trap          = 1'b0;
    trap_cause    = 2'b00;
    if (rst) begin
      w_next = S_FETCH;
    end else begin
      if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
        alu_control  = w_alu_ctl;
        alu_a_source = w_alu_a_pc;
        alu_source   = w_alu_b_imm;
        imm_source   = w_imm_sel;
      end
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load = 1'b1;
            w_next  = S_DECODE;
          end else if (w_timeout) begin
            w_next  = S_TRAP;
            w_cause = c_cause_timeout;
          end
        end
        S_DECODE: begin
          if (w_op_legal) begin
            w_next = S_EXEC;
          end else begin
            w_next  = S_TRAP;
            w_cause = c_cause_illegal;
          end
        end
        S_EXEC: begin
          case (op)
            c_op_load, c_op_store: w_next = S_MEM;
            c_op_op, c_op_imm, c_op_lui, c_op_auipc: w_next = S_WB;
            c_op_branch: begin
              if (w_br_illegal) begin
                w_next  = S_TRAP;
                w_cause = c_cause_illegal;
              end else begin
                pc_write  = 1'b1;
                retire    = 1'b1;
                pc_source = w_br_taken ? c_pc_imm : c_pc_plus4;
                w_next    = S_FETCH;
              end
            end
            c_op_jal, c_op_jalr: begin
              reg_write     = 1'b1;
              result_source = c_res_link;
              pc_write      = 1'b1;
              retire        = 1'b1;
              pc_source     = (op == c_op_jal) ? c_pc_imm : c_pc_alu;
              w_next        = S_FETCH;
            end
            default: begin
              w_next  = S_TRAP;
              w_cause = c_cause_illegal;
            end
          endcase
        end
        S_MEM: begin
          mem_write = (op == c_op_store);
          mem_read  = (op != c_op_store);
          if (dmem_ready) begin
            if (op == c_op_store) begin
              pc_write = 1'b1;
              retire   = 1'b1;
              w_next   = S_FETCH;
            end else begin
              w_next = S_WB;
            end
          end else if (w_timeout) begin
            w_next  = S_TRAP;
            w_cause = c_cause_timeout;
          end
        end
        S_WB: begin
          reg_write     = 1'b1;
          pc_write      = 1'b1;
          retire        = 1'b1;
          result_source = (op == c_op_load) ? c_res_mem :
                          (op == c_op_lui)  ? c_res_imm : c_res_alu;
          w_next        = S_FETCH;
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = r_cause;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  // State register, wait counter (cleared on every state change) and latched trap cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_wait_inc) begin
        r_wait <= r_wait + c_cnt_w'(1);
      end
      if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
        r_cause <= w_cause;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic       c_0 = 1'b0;
  localparam logic       c_1 = 1'b1;
  localparam logic [3:0] c_alu_add = 4'd0, c_alu_sub = 4'd1, c_alu_and = 4'd2,
                         c_alu_or = 4'd3, c_alu_xor = 4'd4, c_alu_slt = 4'd5,
                         c_alu_sltu = 4'd6, c_alu_sll = 4'd7, c_alu_srl = 4'd8,
                         c_alu_sra = 4'd9;
  localparam logic [2:0] c_imm_i = 3'd0, c_imm_s = 3'd1, c_imm_b = 3'd2,
                         c_imm_j = 3'd3, c_imm_u = 3'd4;
  localparam logic [1:0] c_rs_alu = 2'b00, c_rs_mem = 2'b01, c_rs_link = 2'b10, c_rs_imm = 2'b11;
  localparam logic [1:0] c_ps_4 = 2'b00, c_ps_imm = 2'b01, c_ps_alu = 2'b10;
  localparam logic [1:0] c_tc_0 = 2'b00, c_tc_ill = 2'b01, c_tc_to = 2'b10;
  localparam logic [6:0] c_op_r = 7'b0110011, c_op_i = 7'b0010011, c_op_ld = 7'b0000011,
                         c_op_st = 7'b0100011, c_op_br = 7'b1100011, c_op_jal = 7'b1101111,
                         c_op_jalr = 7'b1100111, c_op_lui = 7'b0110111, c_op_auipc = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, rst_nt = 1'b1;
  logic [6:0] op = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic       alu_zero = 1'b0, alu_last_bit = 1'b0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0, imem_ready_nt = 1'b0;

  logic       imem_req, ir_load, alu_a_source, alu_source, mem_read, mem_write;
  logic       reg_write, pc_write, retire, trap;
  logic [3:0] alu_control;
  logic [2:0] imm_source;
  logic [1:0] result_source, pc_source, trap_cause;

  logic       imem_req_nt, ir_load_nt, alu_a_source_nt, alu_source_nt, mem_read_nt, mem_write_nt;
  logic       reg_write_nt, pc_write_nt, retire_nt, trap_nt;
  logic [3:0] alu_control_nt;
  logic [2:0] imm_source_nt;
  logic [1:0] result_source_nt, pc_source_nt, trap_cause_nt;

  logic [22:0] outs, outs_nt, exp;
  logic [22:0] v_req, v_reqld, v_trap_ill, v_trap_to;
  int n_cmp = 0;
  int n_err = 0;

  assign outs = {imem_req, ir_load, alu_control, alu_a_source, alu_source, imm_source,
                 mem_read, mem_write, reg_write, result_source, pc_write, pc_source,
                 retire, trap, trap_cause};
  assign outs_nt = {imem_req_nt, ir_load_nt, alu_control_nt, alu_a_source_nt, alu_source_nt,
                    imm_source_nt, mem_read_nt, mem_write_nt, reg_write_nt, result_source_nt,
                    pc_write_nt, pc_source_nt, retire_nt, trap_nt, trap_cause_nt};

  multicycle_control #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .alu_last_bit(alu_last_bit),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .alu_control(alu_control),
    .alu_a_source(alu_a_source), .alu_source(alu_source), .imm_source(imm_source),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .result_source(result_source), .pc_write(pc_write), .pc_source(pc_source),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_control #(.MAX_WAIT(0)) dut_nt (
    .clk(clk), .rst(rst_nt), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .alu_last_bit(alu_last_bit),
    .imem_ready(imem_ready_nt), .dmem_ready(dmem_ready),
    .imem_req(imem_req_nt), .ir_load(ir_load_nt), .alu_control(alu_control_nt),
    .alu_a_source(alu_a_source_nt), .alu_source(alu_source_nt), .imm_source(imm_source_nt),
    .mem_read(mem_read_nt), .mem_write(mem_write_nt), .reg_write(reg_write_nt),
    .result_source(result_source_nt), .pc_write(pc_write_nt), .pc_source(pc_source_nt),
    .retire(retire_nt), .trap(trap_nt), .trap_cause(trap_cause_nt)
  );

  // Expected output vector, fields in the same order as outs.
  function automatic logic [22:0] ev(input logic req, ld, input logic [3:0] alu,
                                     input logic a, b, input logic [2:0] imm,
                                     input logic mr, mw, rw, input logic [1:0] rs,
                                     input logic pw, input logic [1:0] ps,
                                     input logic ret, tr, input logic [1:0] tc);
    return {req, ld, alu, a, b, imm, mr, mw, rw, rs, pw, ps, ret, tr, tc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; rst_nt = 1; op = c_op_r; imem_ready = 1; dmem_ready = 1;
    tick();
    #1;
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %b want %b", outs, 23'd0); end
    tick();
    rst = 0; rst_nt = 0; imem_ready = 0; dmem_ready = 0;
    #1;
    n_cmp++; if (outs !== v_req) begin n_err++; $display("FAIL reset_fetch: got %b want %b", outs, v_req); end
    tick();
  endtask

  typedef struct packed { logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic [3:0] alu; logic b; } alu_vec_t;

  task automatic test_alu_ops();
    alu_vec_t tab [8] = '{
      '{c_op_r, 3'b000, 7'b0000000, c_alu_add,  c_0},
      '{c_op_r, 3'b000, 7'b0100000, c_alu_sub,  c_0},
      '{c_op_i, 3'b000, 7'b0100000, c_alu_add,  c_1},
      '{c_op_i, 3'b101, 7'b0100000, c_alu_sra,  c_1},
      '{c_op_r, 3'b101, 7'b0000000, c_alu_srl,  c_0},
      '{c_op_r, 3'b011, 7'b0000000, c_alu_sltu, c_0},
      '{c_op_i, 3'b010, 7'b0000000, c_alu_slt,  c_1},
      '{c_op_r, 3'b111, 7'b0000000, c_alu_and,  c_0}};
    alu_vec_t tab2 [3] = '{
      '{c_op_i, 3'b001, 7'b0000000, c_alu_sll,  c_1},
      '{c_op_r, 3'b100, 7'b0000000, c_alu_xor,  c_0},
      '{c_op_i, 3'b110, 7'b0000000, c_alu_or,   c_1}};
    alu_vec_t t;
    for (int i = 0; i < 11; i++) begin
      t = (i < 8) ? tab[i] : tab2[i-8];
      op = t.op; func3 = t.f3; func7 = t.f7; imem_ready = 1;
      #1;
      n_cmp++; if (outs !== v_reqld) begin n_err++; $display("FAIL alu_fetch[%0d]: got %b want %b", i, outs, v_reqld); end
      tick(); imem_ready = 0; #1;
      n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL alu_decode[%0d]: got %b want %b", i, outs, 23'd0); end
      tick(); #1;
      exp = ev(c_0, c_0, t.alu, c_0, t.b, c_imm_i, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
      n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL alu_exec[%0d]: got %b want %b", i, outs, exp); end
      tick(); #1;
      exp = ev(c_0, c_0, t.alu, c_0, t.b, c_imm_i, c_0, c_0, c_1, c_rs_alu, c_1, c_ps_4, c_1, c_0, c_tc_0);
      n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL alu_wb[%0d]: got %b want %b", i, outs, exp); end
      tick();
    end
  endtask

  task automatic test_load_wait();
    op = c_op_ld; func3 = 3'b010; func7 = 0; imem_ready = 1;
    tick(); imem_ready = 0;
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_1, c_imm_i, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL lw_exec: got %b want %b", outs, exp); end
    exp = ev(c_0, c_0, c_alu_add, c_0, c_1, c_imm_i, c_1, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    for (int i = 0; i < 4; i++) begin
      tick(); dmem_ready = (i == 3); #1;
      n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL lw_mem[%0d]: got %b want %b", i, outs, exp); end
    end
    tick(); dmem_ready = 0; #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_1, c_imm_i, c_0, c_0, c_1, c_rs_mem, c_1, c_ps_4, c_1, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL lw_wb_cycle7: got %b want %b", outs, exp); end
    tick(); #1;
    n_cmp++; if (outs !== v_req) begin n_err++; $display("FAIL lw_next_fetch: got %b want %b", outs, v_req); end
    tick();
  endtask

  task automatic test_store();
    op = c_op_st; func3 = 3'b010; func7 = 0; imem_ready = 1;
    tick(); imem_ready = 0;
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_1, c_imm_s, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL sw_exec: got %b want %b", outs, exp); end
    tick(); dmem_ready = 1; #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_1, c_imm_s, c_0, c_1, c_0, c_rs_alu, c_1, c_ps_4, c_1, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL sw_mem: got %b want %b", outs, exp); end
    tick(); dmem_ready = 0; #1;
    n_cmp++; if (outs !== v_req) begin n_err++; $display("FAIL sw_next_fetch: got %b want %b", outs, v_req); end
    tick();
  endtask

  typedef struct packed { logic [2:0] f3; logic z; logic lb; logic [3:0] alu; logic [1:0] ps; } br_vec_t;

  task automatic test_branches();
    br_vec_t tab [6] = '{
      '{3'b001, c_0, c_0, c_alu_sub,  c_ps_imm},
      '{3'b001, c_1, c_0, c_alu_sub,  c_ps_4},
      '{3'b110, c_0, c_1, c_alu_sltu, c_ps_imm},
      '{3'b000, c_1, c_0, c_alu_sub,  c_ps_imm},
      '{3'b101, c_0, c_1, c_alu_slt,  c_ps_4},
      '{3'b111, c_0, c_0, c_alu_sltu, c_ps_imm}};
    for (int i = 0; i < 6; i++) begin
      op = c_op_br; func3 = tab[i].f3; func7 = 0; alu_zero = tab[i].z; alu_last_bit = tab[i].lb;
      imem_ready = 1; #1;
      n_cmp++; if (outs !== v_reqld) begin n_err++; $display("FAIL br_fetch[%0d]: got %b want %b", i, outs, v_reqld); end
      tick(); imem_ready = 0;
      tick(); #1;
      exp = ev(c_0, c_0, tab[i].alu, c_0, c_0, c_imm_b, c_0, c_0, c_0, c_rs_alu, c_1, tab[i].ps, c_1, c_0, c_tc_0);
      n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL br_exec[%0d]: got %b want %b", i, outs, exp); end
      tick();
    end
    alu_zero = 0; alu_last_bit = 0;
  endtask

  task automatic test_jumps();
    op = c_op_jal; func3 = 0; imem_ready = 1;
    tick(); imem_ready = 0;
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_0, c_imm_j, c_0, c_0, c_1, c_rs_link, c_1, c_ps_imm, c_1, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL jal_exec: got %b want %b", outs, exp); end
    tick();
    op = c_op_jalr; imem_ready = 1; #1;
    n_cmp++; if (outs !== v_reqld) begin n_err++; $display("FAIL jalr_fetch: got %b want %b", outs, v_reqld); end
    tick(); imem_ready = 0;
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_1, c_imm_i, c_0, c_0, c_1, c_rs_link, c_1, c_ps_alu, c_1, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL jalr_exec: got %b want %b", outs, exp); end
    tick();
  endtask

  task automatic test_lui_auipc();
    op = c_op_lui; imem_ready = 1;
    tick(); imem_ready = 0;
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_0, c_imm_u, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL lui_exec: got %b want %b", outs, exp); end
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_0, c_0, c_imm_u, c_0, c_0, c_1, c_rs_imm, c_1, c_ps_4, c_1, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL lui_wb: got %b want %b", outs, exp); end
    tick();
    op = c_op_auipc; imem_ready = 1;
    tick(); imem_ready = 0;
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_1, c_1, c_imm_u, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL auipc_exec: got %b want %b", outs, exp); end
    tick(); #1;
    exp = ev(c_0, c_0, c_alu_add, c_1, c_1, c_imm_u, c_0, c_0, c_1, c_rs_alu, c_1, c_ps_4, c_1, c_0, c_tc_0);
    n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL auipc_wb: got %b want %b", outs, exp); end
    tick();
  endtask

  task automatic test_mid_reset();
    op = c_op_st; func3 = 3'b010; imem_ready = 1;
    tick(); imem_ready = 0;
    tick();
    tick(); dmem_ready = 1; rst = 1; #1;
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL midrst_mem: got %b want %b", outs, 23'd0); end
    tick(); rst = 0; dmem_ready = 0; #1;
    n_cmp++; if (outs !== v_req) begin n_err++; $display("FAIL midrst_fetch: got %b want %b", outs, v_req); end
    tick();
  endtask

  task automatic test_illegal();
    int bad;
    op = 7'b0000000; func3 = 0; imem_ready = 1; #1;
    n_cmp++; if (outs !== v_reqld) begin n_err++; $display("FAIL ill_fetch: got %b want %b", outs, v_reqld); end
    tick(); imem_ready = 0; #1;
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL ill_decode: got %b want %b", outs, 23'd0); end
    tick(); #1;
    n_cmp++; if (outs !== v_trap_ill) begin n_err++; $display("FAIL ill_trap: got %b want %b", outs, v_trap_ill); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      imem_ready = i[0]; dmem_ready = i[1];
      tick(); #1;
      if (outs !== v_trap_ill) bad++;
    end
    imem_ready = 0; dmem_ready = 0;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ill_hold: got %0d bad cycles want 0", bad); end
    rst = 1; #1;
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL ill_rst_outs: got %b want %b", outs, 23'd0); end
    tick(); rst = 0; #1;
    n_cmp++; if (outs !== v_req) begin n_err++; $display("FAIL ill_resume: got %b want %b", outs, v_req); end
    tick();
    // Branch with reserved func3 traps from EXEC without retiring.
    op = c_op_br; func3 = 3'b010; imem_ready = 1;
    tick(); imem_ready = 0;
    tick(); #1;
    n_cmp++; if ({pc_write, retire, reg_write} !== 3'b000) begin
      n_err++; $display("FAIL illbr_exec: got %b want 000", {pc_write, retire, reg_write}); end
    tick(); #1;
    n_cmp++; if (outs !== v_trap_ill) begin n_err++; $display("FAIL illbr_trap: got %b want %b", outs, v_trap_ill); end
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_timeout();
    rst = 1; tick(); rst = 0; imem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (outs !== v_req) begin n_err++; $display("FAIL to_fetch_wait[%0d]: got %b want %b", i, outs, v_req); end
      tick();
    end
    #1;
    n_cmp++; if (outs !== v_trap_to) begin n_err++; $display("FAIL to_fetch_trap: got %b want %b", outs, v_trap_to); end
    rst = 1; tick(); rst = 0;
    // Ready arriving after exactly MAX_WAIT waits is still accepted.
    op = c_op_r; func3 = 0; func7 = 0;
    for (int i = 0; i < 4; i++) tick();
    imem_ready = 1; #1;
    n_cmp++; if (outs !== v_reqld) begin n_err++; $display("FAIL to_edge_fetch: got %b want %b", outs, v_reqld); end
    tick(); imem_ready = 0; #1;
    n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL to_edge_decode: got %b want %b", outs, 23'd0); end
    rst = 1; tick(); rst = 0;
    // Data access timeout abandons the load with no writeback.
    op = c_op_ld; func3 = 3'b010; imem_ready = 1;
    tick(); imem_ready = 0;
    tick();
    tick();
    exp = ev(c_0, c_0, c_alu_add, c_0, c_1, c_imm_i, c_1, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (outs !== exp) begin n_err++; $display("FAIL to_mem_wait[%0d]: got %b want %b", i, outs, exp); end
      tick();
    end
    #1;
    n_cmp++; if (outs !== v_trap_to) begin n_err++; $display("FAIL to_mem_trap: got %b want %b", outs, v_trap_to); end
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_no_timeout();
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (outs_nt !== v_req) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL nt_hold: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    v_req      = ev(c_1, c_0, c_alu_add, c_0, c_0, c_imm_i, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    v_reqld    = ev(c_1, c_1, c_alu_add, c_0, c_0, c_imm_i, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_0, c_tc_0);
    v_trap_ill = ev(c_0, c_0, c_alu_add, c_0, c_0, c_imm_i, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_1, c_tc_ill);
    v_trap_to  = ev(c_0, c_0, c_alu_add, c_0, c_0, c_imm_i, c_0, c_0, c_0, c_rs_alu, c_0, c_ps_4, c_0, c_1, c_tc_to);
    test_reset();
    test_alu_ops();
    test_load_wait();
    test_store();
    test_branches();
    test_jumps();
    test_lui_auipc();
    test_mid_reset();
    test_illegal();
    test_timeout();
    test_no_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
